// File: rtl/lvds_frame_scheduler_if.sv
// Bus bundle between the frame scheduler, the host image loader, the shared pixel RAM and the LVDS encoder.
interface lvds_frame_scheduler_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              mode_req;
    logic              host_wr_req;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [23:0]       host_wr_data;
    logic              host_wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [23:0]       mem_wdata;
    logic [23:0]       mem_rdata;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [7:0]        red;
    logic [7:0]        green;
    logic [7:0]        blue;
    logic              frame_start;
    logic              mode_active;

    // master: the scheduler (drives the RAM port and the video stream)
    modport master (
        input  mode_req, host_wr_req, host_wr_addr, host_wr_data, mem_rdata,
        output host_wr_ack, mem_addr, mem_we, mem_wdata,
        output hsync, vsync, de, red, green, blue, frame_start, mode_active
    );

    modport slave (
        output mode_req, host_wr_req, host_wr_addr, host_wr_data, mem_rdata,
        input  host_wr_ack, mem_addr, mem_we, mem_wdata,
        input  hsync, vsync, de, red, green, blue, frame_start, mode_active
    );
endinterface

// File: rtl/lvds_frame_scheduler.sv
// Raster timing, per-frame pixel-source select and pixel-RAM arbitration for the LVDS encoder (dot clock).
// Optional build macro LVDS_SCHED_WR_VBLANK_ONLY_EN: host writes are granted only during vertical blanking.
module lvds_frame_scheduler #(
    parameter int unsigned H_ACTIVE = 1365,
    parameter int unsigned H_BLANK  = 50,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_BLANK  = 12,
    parameter int unsigned IMG_W    = 102,
    parameter int unsigned IMG_H    = 102,
    parameter int unsigned ADDR_W   = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lvds_frame_scheduler_if.master bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int unsigned XW      = $clog2(H_TOTAL);
    localparam int unsigned YW      = $clog2(V_TOTAL);
    localparam int unsigned AW1     = ADDR_W + 1;

    localparam logic [XW-1:0]  X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0]  X_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0]  X_HS_END = XW'(H_ACTIVE + H_BLANK / 2);
    localparam logic [XW-1:0]  X_IMG    = XW'(IMG_W);
    localparam logic [YW-1:0]  Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0]  Y_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0]  Y_VS_END = YW'(V_ACTIVE + V_BLANK / 2);
    localparam logic [YW-1:0]  Y_IMG    = YW'(IMG_H);
    localparam logic [AW1-1:0] IMG_PIX  = AW1'(IMG_W * IMG_H);

    function automatic logic [2:0] bar_index(input logic [XW-1:0] xv);
        logic [2:0] idx;
        idx = '0;
        for (int k = 1; k < 8; k++)
            if (xv >= XW'((k * H_ACTIVE) / 8)) idx = idx + 3'd1;
        return idx;
    endfunction

    // Bar index bits map straight onto colour channels: bit1 red, bit2 green, bit0 blue.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        return {{8{idx[1]}}, {8{idx[2]}}, {8{idx[0]}}};
    endfunction

    logic [XW-1:0]     x_p0;
    logic [YW-1:0]     y_p0;
    logic              mode_active_q;

    logic              sof_p0;
    logic              frame_mode;
    logic              hs_p0, vs_p0, de_p0;
    logic              in_rows, in_win, disp_claim, wr_window, grant, addr_ok;
    logic [ADDR_W-1:0] pix_addr;

    logic              hs_p1, vs_p1, de_p1, sof_p1, use_ram_p1;
    logic [23:0]       rgb_p1;
    logic [ADDR_W-1:0] mem_addr_p1;
    logic              mem_we_p1, wr_ack_p1;
    logic [23:0]       mem_wdata_p1;

    logic              hs_p2, vs_p2, de_p2, sof_p2, use_ram_p2;
    logic [23:0]       rgb_p2;
    logic [23:0]       rgb_out;

    // Stage 0: raster counters and frame-level source register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_p0          <= '0;
            y_p0          <= '0;
            mode_active_q <= 1'b1;
        end else begin
            if (x_p0 == X_LAST) begin
                x_p0 <= '0;
                y_p0 <= (y_p0 == Y_LAST) ? '0 : y_p0 + YW'(1);
            end else begin
                x_p0 <= x_p0 + XW'(1);
            end
            if (sof_p0) mode_active_q <= bus.mode_req;
        end
    end

    always_comb begin
        sof_p0     = (x_p0 == '0) && (y_p0 == '0);
        // The first pixel of a frame already uses the freshly sampled source.
        frame_mode = sof_p0 ? bus.mode_req : mode_active_q;
        hs_p0      = !((x_p0 > X_ACT) && (x_p0 < X_HS_END));
        vs_p0      = !((y_p0 > Y_ACT) && (y_p0 < Y_VS_END));
        de_p0      = (x_p0 < X_ACT) && (y_p0 < Y_ACT);
        in_rows    = (y_p0 < Y_IMG);
        in_win     = in_rows && (x_p0 < X_IMG);
        disp_claim = !frame_mode && in_win;
`ifdef LVDS_SCHED_WR_VBLANK_ONLY_EN
        wr_window  = (y_p0 >= Y_ACT);
`else
        wr_window  = 1'b1;
`endif
        // A request still held during its own ack cycle must not be granted twice.
        grant      = bus.host_wr_req && !disp_claim && wr_window && !wr_ack_p1;
        addr_ok    = ({1'b0, bus.host_wr_addr} < IMG_PIX);
        pix_addr   = ADDR_W'(32'(y_p0) * IMG_W + 32'(x_p0));
    end

    // Stage 1: RAM request, source select, timing delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_p1        <= 1'b1;
            vs_p1        <= 1'b1;
            de_p1        <= 1'b0;
            sof_p1       <= 1'b0;
            use_ram_p1   <= 1'b0;
            rgb_p1       <= '0;
            mem_addr_p1  <= '0;
            mem_we_p1    <= 1'b0;
            mem_wdata_p1 <= '0;
            wr_ack_p1    <= 1'b0;
        end else begin
            hs_p1      <= hs_p0;
            vs_p1      <= vs_p0;
            de_p1      <= de_p0;
            sof_p1     <= sof_p0;
            use_ram_p1 <= disp_claim && de_p0;
            if (!de_p0)
                rgb_p1 <= '0;
            else if (frame_mode)
                rgb_p1 <= bar_rgb(bar_index(x_p0));
            else
                rgb_p1 <= in_rows ? 24'hFF0000 : 24'hFFFFFF;
            wr_ack_p1 <= grant;
            mem_we_p1 <= grant && addr_ok;
            if (disp_claim)
                mem_addr_p1 <= pix_addr;
            else if (grant)
                mem_addr_p1 <= bus.host_wr_addr;
            if (grant) mem_wdata_p1 <= bus.host_wr_data;
        end
    end

    // Stage 2: output registers; RAM data arrives here one cycle after its address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_p2      <= 1'b1;
            vs_p2      <= 1'b1;
            de_p2      <= 1'b0;
            sof_p2     <= 1'b0;
            use_ram_p2 <= 1'b0;
            rgb_p2     <= '0;
        end else begin
            hs_p2      <= hs_p1;
            vs_p2      <= vs_p1;
            de_p2      <= de_p1;
            sof_p2     <= sof_p1;
            use_ram_p2 <= use_ram_p1;
            rgb_p2     <= rgb_p1;
        end
    end

    assign rgb_out         = use_ram_p2 ? bus.mem_rdata : rgb_p2;
    assign bus.red         = rgb_out[23:16];
    assign bus.green       = rgb_out[15:8];
    assign bus.blue        = rgb_out[7:0];
    assign bus.hsync       = hs_p2;
    assign bus.vsync       = vs_p2;
    assign bus.de          = de_p2;
    assign bus.frame_start = sof_p2;
    assign bus.mode_active = mode_active_q;
    assign bus.mem_addr    = mem_addr_p1;
    assign bus.mem_we      = mem_we_p1;
    assign bus.mem_wdata   = mem_wdata_p1;
    assign bus.host_wr_ack = wr_ack_p1;
endmodule

// File: tb/tb_lvds_frame_scheduler.sv
// Randomized scoreboard bench for lvds_frame_scheduler on a shrunken raster with a behavioural reference model.
module tb_lvds_frame_scheduler;
    localparam int unsigned HA   = 43;
    localparam int unsigned HB   = 10;
    localparam int unsigned VA   = 12;
    localparam int unsigned VB   = 4;
    localparam int unsigned IW   = 6;
    localparam int unsigned IH   = 5;
    localparam int unsigned AW   = 5;
    localparam int unsigned HT   = HA + HB;
    localparam int unsigned VT   = VA + VB;
    localparam int unsigned NPIX = IW * IH;
    localparam int unsigned NMEM = 1 << AW;

    localparam logic [23:0] BAR [8] = '{24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
                                        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [23:0] rgb;
    } pix_t;

    typedef struct {
        logic          ack;
        logic          we;
        logic          chk_addr;
        logic [AW-1:0] addr;
        logic [23:0]   wdata;
        logic          mode;
    } busx_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lvds_frame_scheduler_if #(.ADDR_W(AW)) bus ();

    lvds_frame_scheduler #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
        .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endfunction

    // Pixel RAM seen by the DUT: one-cycle read latency
    logic [23:0] ram [0:NMEM-1];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [23:0]   model_ram [0:NMEM-1];
    int unsigned   t = 0;
    logic          model_mode = 1'b1;
    logic          prev_grant = 1'b0;
    pix_t          pix_q [$];
    busx_t         bus_q [$];
    int unsigned   mx, my;
    logic          m_win, m_claim, m_wr_ok, m_grant;
    pix_t          mp;
    busx_t         mb;

    function automatic int bar_of(input int unsigned xv);
        int b;
        b = 0;
        for (int k = 1; k < 8; k++)
            if (xv >= (k * HA) / 8) b = k;
        return b;
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            mx = t % HT;
            my = (t / HT) % VT;
            if (mx == 0 && my == 0) model_mode = bus.mode_req;
            m_win   = (my < IH) && (mx < IW);
            m_claim = !model_mode && m_win;
            m_wr_ok = 1'b1;
`ifdef LVDS_SCHED_WR_VBLANK_ONLY_EN
            m_wr_ok = (my >= VA);
`endif
            m_grant = bus.host_wr_req && !m_claim && m_wr_ok && !prev_grant;

            mp.de = (mx < HA) && (my < VA);
            mp.hs = !((mx > HA) && (mx < HA + HB / 2));
            mp.vs = !((my > VA) && (my < VA + VB / 2));
            mp.fs = (mx == 0) && (my == 0);
            if (!mp.de)          mp.rgb = 24'h000000;
            else if (model_mode) mp.rgb = BAR[bar_of(mx)];
            else if (m_win)      mp.rgb = model_ram[my * IW + mx];
            else if (my < IH)    mp.rgb = 24'hFF0000;
            else                 mp.rgb = 24'hFFFFFF;
            pix_q.push_back(mp);

            mb.ack      = m_grant;
            mb.we       = m_grant && (int'(bus.host_wr_addr) < NPIX);
            mb.chk_addr = m_claim || m_grant;
            mb.addr     = m_claim ? AW'(my * IW + mx) : bus.host_wr_addr;
            mb.wdata    = bus.host_wr_data;
            mb.mode     = model_mode;
            bus_q.push_back(mb);

            if (mb.we) model_ram[bus.host_wr_addr] = bus.host_wr_data;
            prev_grant = m_grant;
            t++;
        end
    end

    // Monitor: RAM/handshake side one cycle after the decision, video side two cycles after
    busx_t       eb;
    pix_t        ep;
    int unsigned last_fs = 0;
    bit          last_fs_valid = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_q.size() >= 1) begin
                eb = bus_q.pop_front();
                chk("host_wr_ack", 32'(bus.host_wr_ack), 32'(eb.ack));
                chk("mem_we", 32'(bus.mem_we), 32'(eb.we));
                chk("mode_active", 32'(bus.mode_active), 32'(eb.mode));
                if (eb.chk_addr) chk("mem_addr", 32'(bus.mem_addr), 32'(eb.addr));
                if (eb.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(eb.wdata));
            end
            if (pix_q.size() >= 2) begin
                ep = pix_q.pop_front();
                chk("hsync", 32'(bus.hsync), 32'(ep.hs));
                chk("vsync", 32'(bus.vsync), 32'(ep.vs));
                chk("de", 32'(bus.de), 32'(ep.de));
                chk("frame_start", 32'(bus.frame_start), 32'(ep.fs));
                chk("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(ep.rgb));
            end
            if (bus.frame_start) begin
                if (last_fs_valid) chk("frame_period", cyc - last_fs, HT * VT);
                last_fs       = cyc;
                last_fs_valid = 1'b1;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hsync"}, 32'(bus.hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(bus.vsync), 32'd1);
        chk({tag, "_de"}, 32'(bus.de), 32'd0);
        chk({tag, "_rgb"}, 32'({bus.red, bus.green, bus.blue}), 32'd0);
        chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
        chk({tag, "_mode_active"}, 32'(bus.mode_active), 32'd1);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_host_wr_ack"}, 32'(bus.host_wr_ack), 32'd0);
    endtask

    task automatic flush_model();
        pix_q.delete();
        bus_q.delete();
        t             = 0;
        prev_grant    = 1'b0;
        model_mode    = 1'b1;
        last_fs_valid = 1'b0;
    endtask

    // Holds the request through the ack cycle and one more, so the double-grant guard is exercised.
    task automatic host_write(input logic [AW-1:0] a, input logic [23:0] d);
        bit got;
        bus.host_wr_addr = a;
        bus.host_wr_data = d;
        bus.host_wr_req  = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(posedge clk); #1;
            if (bus.host_wr_ack) got = 1'b1;
        end
        chk("host_ack_within_bound", 32'(got), 32'd1);
        if (got) begin
            @(posedge clk); #1;
        end
        bus.host_wr_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic random_traffic(input int unsigned until_cyc, input bit vary_mode);
        logic [AW-1:0] a;
        while (cyc < until_cyc) begin
            if (vary_mode && $urandom_range(0, 3) == 0) bus.mode_req = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 40)) begin
                @(posedge clk); #1;
            end
            if ($urandom_range(0, 4) == 0) a = AW'($urandom_range(NPIX, NMEM - 1));
            else                           a = AW'($urandom_range(0, NPIX - 1));
            host_write(a, 24'($urandom));
        end
    endtask

    logic [23:0] init_v;

    initial begin
        bus.mode_req     = 1'b1;
        bus.host_wr_req  = 1'b0;
        bus.host_wr_addr = '0;
        bus.host_wr_data = '0;
        for (int i = 0; i < int'(NMEM); i++) begin
            init_v       = 24'($urandom);
            ram[i]       = init_v;
            model_ram[i] = init_v;
        end

        #12;
        check_reset_outputs("reset");
        @(posedge clk); #3;
        rst_n = 1'b1;

        random_traffic(cyc + 2 * HT * VT, 1'b0);
        bus.mode_req = 1'b0;
        random_traffic(cyc + 3 * HT * VT, 1'b0);
        random_traffic(cyc + 6 * HT * VT, 1'b1);

        // Asynchronous reset in the middle of an active line
        for (int n = 0; n < int'(HT * VT) + 1; n++) begin
            @(posedge clk); #3;
            if ((t % HT) == 20 && ((t / HT) % VT) == 7) break;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        flush_model();
        bus.mode_req = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;

        random_traffic(cyc + 2 * HT * VT, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
